// File: rtl/pci_pkg.sv
// pci_pkg: shared arbiter state encoding, parameter defaults and bus-idle helper
package pci_pkg;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, TURNAROUND} arbState_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int GNT_TIMEOUT_DEF = 16;
  function automatic logic busIdle(input logic frameN, input logic irdyN);
    return frameN & irdyN;
  endfunction
endpackage

// File: rtl/pci_rr_pick.sv
// pci_rr_pick: combinational round-robin winner search starting just after the last owner
module pci_rr_pick import pci_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       last,
  output logic               valid,
  output logic [W-1:0]       winner
);
  logic [W-1:0] idx;
  assign valid = |req;
  // scan farthest offset first so the nearest requester after last ends up as winner
  always_comb begin
    idx = '0;
    winner = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = W'((int'(last) + i) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter; define PCI_ARB_PARK_EN to park the bus on the last owner
module pci_arbiter import pci_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req_n,
  input  logic               frame_n,
  input  logic               irdy_n,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic [W-1:0]       owner,
  output logic               bus_busy
);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);
  arbState_t state;
  logic [CW-1:0] tmoCnt;
  logic [NUM_REQ-1:0] reqVec, ownerMask;
  logic pickValid, othersReq, idle;
  logic [W-1:0] pickIdx;
  assign reqVec = ~req_n;
  assign ownerMask = NUM_REQ'(1) << owner;
  assign othersReq = |(reqVec & ~ownerMask);
  assign idle = busIdle(frame_n, irdy_n);
  pci_rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
    .req(reqVec),
    .last(owner),
    .valid(pickValid),
    .winner(pickIdx)
  );
  // arbitration FSM; grants, owner and bus_busy are all registered here
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      gnt_n <= '1;
      owner <= W'(NUM_REQ - 1);
      bus_busy <= 1'b0;
      tmoCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
`ifdef PCI_ARB_PARK_EN
          if (gnt_n != '1) begin
            if (!frame_n) begin
              state <= BUSY;
              bus_busy <= 1'b1;
            end else if (othersReq) begin
              gnt_n <= '1;
              state <= TURNAROUND;
            end else if (reqVec[owner]) begin
              tmoCnt <= '0;
              state <= GRANTED;
            end
          end else if (!frame_n) begin
`else
          if (!frame_n) begin
`endif
            state <= BUSY;
            bus_busy <= 1'b1;
          end else if (pickValid) begin
            gnt_n <= ~(NUM_REQ'(1) << pickIdx);
            owner <= pickIdx;
            tmoCnt <= '0;
            state <= GRANTED;
          end
`ifdef PCI_ARB_PARK_EN
          else gnt_n <= ~ownerMask;
`endif
        end
        GRANTED: begin
          if (!frame_n) begin
            state <= BUSY;
            bus_busy <= 1'b1;
          end else if (req_n[owner] || tmoCnt == CW'(GNT_TIMEOUT - 1)) begin
            gnt_n <= '1;
            state <= TURNAROUND;
          end else tmoCnt <= tmoCnt + CW'(1);
        end
        BUSY: begin
          if (req_n[owner] || othersReq) gnt_n <= '1;
          if (idle) begin
            gnt_n <= '1;
            bus_busy <= 1'b0;
            state <= TURNAROUND;
          end
        end
        TURNAROUND: begin
          gnt_n <= '1;
          bus_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed scenarios with a grant-order scoreboard for pci_arbiter
module tb_pci_arbiter;
  logic clk = 1'b0;
  logic RST = 1'b0;
  logic [3:0] req_n = 4'b1111;
  logic frame_n = 1'b1;
  logic irdy_n = 1'b1;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic bus_busy;
  int errors = 0;
  int checks = 0;
  int expQ[$];
`ifdef PCI_ARB_PARK_EN
  localparam logic [3:0] PARK_GNT = 4'b1011;
  localparam int PARK_LAT = 3;
`else
  localparam logic [3:0] PARK_GNT = 4'b1111;
  localparam int PARK_LAT = 1;
`endif

  pci_arbiter #(.NUM_REQ(4), .GNT_TIMEOUT(16)) dut (
    .clk(clk),
    .RST(RST),
    .req_n(req_n),
    .frame_n(frame_n),
    .irdy_n(irdy_n),
    .gnt_n(gnt_n),
    .owner(owner),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset;
    RST = 1'b0;
    req_n = 4'b1111;
    frame_n = 1'b1;
    irdy_n = 1'b1;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic waitGrant(input string tag, output int n);
    int e;
    logic [3:0] expGnt;
    n = 0;
    while (gnt_n === 4'b1111 && n < 40) begin
      tick();
      n++;
    end
    e = (expQ.size() > 0) ? expQ.pop_front() : 0;
    expGnt = ~(4'b0001 << e);
    check({tag, "_gnt"}, 32'(gnt_n), 32'(expGnt));
    check({tag, "_owner"}, 32'(owner), 32'(e));
    check({tag, "_onehot"}, 32'($countones(~gnt_n)), 32'd1);
  endtask

  task automatic burst(input string tag);
    frame_n = 1'b0;
    irdy_n = 1'b1;
    tick();
    check({tag, "_busy"}, 32'(bus_busy), 32'd1);
    irdy_n = 1'b0;
    tick();
    check({tag, "_release"}, 32'(gnt_n), 32'hf);
    tick();
    frame_n = 1'b1;
    tick();
    irdy_n = 1'b1;
    tick();
    check({tag, "_idle"}, 32'(bus_busy), 32'd0);
  endtask

  initial begin
    int n;
    doReset();
    check("rst_gnt", 32'(gnt_n), 32'hf);
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_busy", 32'(bus_busy), 32'd0);

    req_n = 4'b1110;
    expQ.push_back(0);
    waitGrant("s1", n);
    check("s1_lat", 32'(n), 32'd1);
    req_n = 4'b1111;
    tick();
    check("s1_drop", 32'(gnt_n), 32'hf);

    doReset();
    req_n = 4'b0000;
    foreach (expQ[i]) expQ.delete(i);
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(2);
    expQ.push_back(3);
    expQ.push_back(0);
    for (int k = 0; k < 5; k++) begin
      waitGrant("s2", n);
      check("s2_lat", 32'(n), (k == 0) ? 32'd1 : 32'd2);
      if (k < 4) burst("s2");
    end

    doReset();
    req_n = 4'b0011;
    expQ.push_back(2);
    expQ.push_back(3);
    waitGrant("s3a", n);
    n = 0;
    while (gnt_n[2] === 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("s3_timeout", 32'(n), 32'd16);
    waitGrant("s3b", n);
    check("s3_lat", 32'(n), 32'd2);

    doReset();
    req_n = 4'b1101;
    expQ.push_back(1);
    waitGrant("s4a", n);
    frame_n = 1'b0;
    tick();
    check("s4_hold", 32'(gnt_n), 32'hd);
    irdy_n = 1'b0;
    req_n = 4'b0101;
    tick();
    check("s4_release", 32'(gnt_n), 32'hf);
    check("s4_busy", 32'(bus_busy), 32'd1);
    frame_n = 1'b1;
    tick();
    irdy_n = 1'b1;
    tick();
    expQ.push_back(3);
    waitGrant("s4b", n);
    check("s4_lat", 32'(n), 32'd2);

    frame_n = 1'b0;
    tick();
    check("s5_busy", 32'(bus_busy), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check("s5_gnt", 32'(gnt_n), 32'hf);
    check("s5_busy_rst", 32'(bus_busy), 32'd0);
    check("s5_owner", 32'(owner), 32'd3);
    tick();
    RST = 1'b1;
    frame_n = 1'b1;
    req_n = 4'b1110;
    expQ.push_back(0);
    waitGrant("s5", n);
    check("s5_lat", 32'(n), 32'd1);

    doReset();
    frame_n = 1'b0;
    irdy_n = 1'b0;
    req_n = 4'b1110;
    tick();
    check("s7_gnt", 32'(gnt_n), 32'hf);
    check("s7_busy", 32'(bus_busy), 32'd1);
    frame_n = 1'b1;
    irdy_n = 1'b1;
    tick();
    expQ.push_back(0);
    waitGrant("s7", n);
    check("s7_lat", 32'(n), 32'd2);

    doReset();
    req_n = 4'b1011;
    expQ.push_back(2);
    waitGrant("s6", n);
    req_n = 4'b1111;
    tick();
    check("s6_turn", 32'(gnt_n), 32'hf);
    tick();
    check("s6_idle", 32'(gnt_n), 32'hf);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s6_park", 32'(gnt_n), 32'(PARK_GNT));
    end
    req_n = 4'b1110;
    n = 0;
    while (gnt_n !== 4'b1110 && n < 10) begin
      tick();
      n++;
    end
    check("s6_next_gnt", 32'(gnt_n), 32'he);
    check("s6_next_owner", 32'(owner), 32'd0);
    check("s6_next_lat", 32'(n), 32'(PARK_LAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
